// File: rtl/line_to_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_to_block_buffer
// Description : Raster-to-block reorder stage in front of the JPEG encoder.
//               Collects 8 raster lines of one colour component (8 pixels per
//               beat) into one bank of a ping-pong line RAM. It then re-emits
//               the buffered lines as 8x8 blocks, one 8-pixel block row per
//               beat, with the level shift (pixel - 128) applied.
// Ports       : clk        block clock
//               resetn     asynchronous active-low reset
//               in_data    8 unsigned pixels, lane 0 leftmost (LSBs)
//               in_valid   in_data valid
//               in_hold    back-pressure to source
//               x_size_m1  image width - 1  (multiple of 8, minus 1)
//               y_size_m1  image height - 1 (multiple of 8, minus 1)
//               out_data   8 signed level-shifted pixels, lane 0 leftmost
//               out_valid  out_data valid
//               out_hold   sink back-pressure
//               out_cnt    row index inside the current 8x8 block
//               out_last   row 7 of the last block of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module line_to_block_buffer #(
    parameter int DW            = 8,
    parameter int SENSOR_X_SIZE = 1280,
    parameter int SENSOR_Y_SIZE = 720
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [8*DW-1:0]                  in_data,
    input  logic                             in_valid,
    output logic                             in_hold,
    input  logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_m1,
    input  logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_m1,
    output logic [8*DW-1:0]                  out_data,
    output logic                             out_valid,
    input  logic                             out_hold,
    output logic [2:0]                       out_cnt,
    output logic                             out_last
);

    localparam int c_XW     = $clog2(SENSOR_X_SIZE);
    localparam int c_YW     = $clog2(SENSOR_Y_SIZE);
    localparam int c_BW     = c_XW - 3;                 // beat index width
    localparam int c_GW     = c_YW - 3;                 // line-group index width
    localparam int c_DEPTH  = 8 * (SENSOR_X_SIZE / 8);  // words per bank
    localparam int c_LAW    = $clog2(c_DEPTH);          // in-bank address width
    localparam int c_AW     = $clog2(2 * c_DEPTH);      // full RAM address width
    localparam logic [DW-1:0] c_OFFSET = DW'(128);

    // ------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------
    logic [c_BW-1:0]  w_w8_m1;   // beats per line - 1
    logic [c_GW-1:0]  w_ng_m1;   // line groups per frame - 1
    logic [c_LAW-1:0] w_w8;      // beats per line, address width

    assign w_w8_m1 = x_size_m1[c_XW-1:3];
    assign w_ng_m1 = y_size_m1[c_YW-1:3];
    assign w_w8    = c_LAW'(w_w8_m1) + c_LAW'(1);

    // ------------------------------------------------------------------
    // Storage: both banks live in one array; bank 1 sits above bank 0
    // ------------------------------------------------------------------
    logic [8*DW-1:0] r_mem [0:2*c_DEPTH-1];
    logic [8*DW-1:0] r_ram_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [c_BW-1:0]  r_wx;
    logic [2:0]       r_wr;
    logic             r_wbank;
    logic [c_LAW-1:0] r_waddr;   // equals wr*W8 + wx; lines are contiguous
    logic [c_GW-1:0]  r_wy;
    logic [1:0]       r_full;
    logic [1:0]       r_bank_last; // bank holds the last group of its frame

    logic             w_wr_en;
    logic             w_wline_end;
    logic             w_wbank_done;
    logic [c_AW-1:0]  w_wa;

    assign in_hold      = r_full[r_wbank];
    assign w_wr_en      = in_valid && !in_hold;
    assign w_wline_end  = (r_wx == w_w8_m1);
    assign w_wbank_done = w_wline_end && (r_wr == 3'd7);
    assign w_wa         = r_wbank ? c_AW'(r_waddr) + c_AW'(c_DEPTH) : c_AW'(r_waddr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wx    <= '0;
            r_wr    <= '0;
            r_wbank <= 1'b0;
            r_waddr <= '0;
            r_wy    <= '0;
        end else if (w_wr_en) begin
            if (w_wline_end) begin
                r_wx <= '0;
                r_wr <= r_wr + 3'd1;
            end else begin
                r_wx <= r_wx + c_BW'(1);
            end
            if (w_wbank_done) begin
                r_waddr <= '0;
                r_wbank <= ~r_wbank;
                r_wy    <= (r_wy == w_ng_m1) ? '0 : r_wy + c_GW'(1);
            end else begin
                r_waddr <= r_waddr + c_LAW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic [c_BW-1:0]  r_rb;
    logic [2:0]       r_rr;
    logic             r_rbank;
    logic [c_LAW-1:0] r_rbase;   // rr*W8, kept incrementally

    logic             w_rd_en;
    logic             w_rrow_end;
    logic             w_rbank_done;
    logic [c_LAW-1:0] w_ra_local;
    logic [c_AW-1:0]  w_ra;

    // Read-pipeline / skid state
    logic             r_p_valid;         // r_ram_q holds a row this cycle
    logic [2:0]       r_p_cnt;
    logic             r_p_last;
    logic [8*DW-1:0]  r_sk_data [0:1];
    logic [2:0]       r_sk_cnt  [0:1];
    logic [1:0]       r_sk_last;
    logic [1:0]       r_sk_n;

    logic             w_pop;
    logic             w_fpop;
    logic             w_push;
    logic [1:0]       w_n_after;
    logic [2:0]       w_occ;

    assign w_rrow_end   = (r_rr == 3'd7);
    assign w_rbank_done = w_rrow_end && (r_rb == w_w8_m1);
    assign w_ra_local   = r_rbase + c_LAW'(r_rb);
    assign w_ra         = r_rbank ? c_AW'(w_ra_local) + c_AW'(c_DEPTH) : c_AW'(w_ra_local);

    // Rows held after this cycle (skid + in-flight read, minus what leaves).
    // A new read is only issued if its row is guaranteed a skid slot, so a
    // read in flight never has to be cancelled or stalled.
    assign w_pop   = out_valid && !out_hold;
    assign w_occ   = {1'b0, r_sk_n} + {2'b00, r_p_valid} - {2'b00, w_pop};
    assign w_rd_en = r_full[r_rbank] && (w_occ < 3'd2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rb      <= '0;
            r_rr      <= '0;
            r_rbank   <= 1'b0;
            r_rbase   <= '0;
            r_p_valid <= 1'b0;
            r_p_cnt   <= '0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= w_rd_en;
            if (w_rd_en) begin
                r_p_cnt  <= r_rr;
                r_p_last <= r_bank_last[r_rbank] && w_rbank_done;
                if (w_rrow_end) begin
                    r_rr    <= '0;
                    r_rbase <= '0;
                    if (w_rbank_done) begin
                        r_rb    <= '0;
                        r_rbank <= ~r_rbank;
                    end else begin
                        r_rb <= r_rb + c_BW'(1);
                    end
                end else begin
                    r_rr    <= r_rr + 3'd1;
                    r_rbase <= r_rbase + w_w8;
                end
            end
        end
    end

    // Bank status. Write-fill and read-drain always target different banks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_full      <= '0;
            r_bank_last <= '0;
        end else begin
            if (w_wr_en && w_wbank_done) begin
                r_full[r_wbank]      <= 1'b1;
                r_bank_last[r_wbank] <= (r_wy == w_ng_m1);
            end
            if (w_rd_en && w_rbank_done) begin
                r_full[r_rbank] <= 1'b0;
            end
        end
    end

    // Inferred RAM: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wa] <= in_data;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[w_ra];
        end
    end

    // ------------------------------------------------------------------
    // Two-entry skid. When it is empty the RAM register drives the output
    // directly; a row that is not taken moves into the skid next cycle.
    // ------------------------------------------------------------------
    assign w_fpop    = w_pop && (r_sk_n != 2'd0);
    assign w_push    = r_p_valid && !((r_sk_n == 2'd0) && w_pop);
    assign w_n_after = r_sk_n - {1'b0, w_fpop};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sk_data[0] <= '0;
            r_sk_data[1] <= '0;
            r_sk_cnt[0]  <= '0;
            r_sk_cnt[1]  <= '0;
            r_sk_last    <= '0;
            r_sk_n       <= '0;
        end else begin
            if (w_fpop) begin
                r_sk_data[0] <= r_sk_data[1];
                r_sk_cnt[0]  <= r_sk_cnt[1];
                r_sk_last[0] <= r_sk_last[1];
            end
            if (w_push) begin
                if (w_n_after == 2'd0) begin
                    r_sk_data[0] <= r_ram_q;
                    r_sk_cnt[0]  <= r_p_cnt;
                    r_sk_last[0] <= r_p_last;
                end else begin
                    r_sk_data[1] <= r_ram_q;
                    r_sk_cnt[1]  <= r_p_cnt;
                    r_sk_last[1] <= r_p_last;
                end
            end
            r_sk_n <= w_n_after + {1'b0, w_push};
        end
    end

    // ------------------------------------------------------------------
    // Output head and level shift
    // ------------------------------------------------------------------
    logic [8*DW-1:0] w_head_data;
    logic [2:0]      w_head_cnt;
    logic            w_head_last;
    logic [8*DW-1:0] w_shift;

    assign w_head_data = (r_sk_n != 2'd0) ? r_sk_data[0] : r_ram_q;
    assign w_head_cnt  = (r_sk_n != 2'd0) ? r_sk_cnt[0]  : r_p_cnt;
    assign w_head_last = (r_sk_n != 2'd0) ? r_sk_last[0] : r_p_last;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_lane
            assign w_shift[i*DW +: DW] = w_head_data[i*DW +: DW] - c_OFFSET;
        end
    endgenerate

    // Outputs are forced to zero when idle so the RAM register (not reset)
    // never leaks onto the bus.
    assign out_valid = (r_sk_n != 2'd0) || r_p_valid;
    assign out_data  = out_valid ? w_shift     : '0;
    assign out_cnt   = out_valid ? w_head_cnt  : 3'd0;
    assign out_last  = out_valid ? w_head_last : 1'b0;

    // Frame dimensions must be multiples of 8 and fit the line RAM
    a_dims : assert property (@(posedge clk) disable iff (!resetn)
        in_valid |-> (x_size_m1[2:0] == 3'b111) && (y_size_m1[2:0] == 3'b111)
                     && (int'(x_size_m1) < SENSOR_X_SIZE))
        else $fatal(1, "line_to_block_buffer: illegal frame dimensions");

endmodule
`default_nettype wire

// File: tb/tb_line_to_block_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_to_block_buffer
// Description : Scoreboard bench for line_to_block_buffer. The driver builds
//               an 8-line model of each line group and pushes the expected
//               block rows; the monitor pops and compares on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_to_block_buffer;

    logic        clk;
    logic        resetn;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_hold;
    logic [10:0] x_size_m1;
    logic [9:0]  y_size_m1;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_hold;
    logic [2:0]  out_cnt;
    logic        out_last;

    line_to_block_buffer dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_hold   (in_hold),
        .x_size_m1 (x_size_m1),
        .y_size_m1 (y_size_m1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_hold  (out_hold),
        .out_cnt   (out_cnt),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  c;
        logic        l;
    } exp_t;

    exp_t q[$];

    int   r_checks = 0;
    int   r_errors = 0;
    int   cyc = 0;
    int   hold_pct = 0;
    bit   hold_force = 0;
    int   n_last = 0;
    int   n_acc = 0;
    int   t_last_in = 0;
    int   t_first_out = -1;
    bit   arm_first = 0;

    logic [7:0] lb [0:7][0:159][0:7];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic finish_all();
        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    endtask

    function automatic logic [7:0] pixel(input int pat, input int x, input int y);
        logic [7:0] vals [0:2];
        vals[0] = 8'd0;
        vals[1] = 8'd128;
        vals[2] = 8'd255;
        case (pat)
            0:       return 8'((x + 16 * y) & 255);
            1:       return vals[(x + y) % 3];
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    // Present one beat starting at a negedge; returns at the negedge after
    // the beat transferred.
    task automatic put_beat(input logic [63:0] d, input int vpct);
        int guard;
        guard = 0;
        while (int'($urandom_range(99)) >= vpct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        while (in_hold) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                check("in_hold_timeout", 64'd1, 64'd0);
                finish_all();
            end
        end
        n_acc++;
        t_last_in = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int pat, input int vpct,
                              input int max_lines);
        int nb;
        nb = w / 8;
        x_size_m1 = 11'(w - 1);
        y_size_m1 = 10'(h - 1);
        for (int y = 0; y < h && y < max_lines; y++) begin
            for (int b = 0; b < nb; b++) begin
                logic [63:0] d;
                for (int l = 0; l < 8; l++) begin
                    logic [7:0] px;
                    px = pixel(pat, b * 8 + l, y);
                    d[l*8 +: 8] = px;
                    lb[y % 8][b][l] = px;
                end
                put_beat(d, vpct);
            end
            if (y % 8 == 7) begin
                for (int bb = 0; bb < nb; bb++) begin
                    for (int r = 0; r < 8; r++) begin
                        exp_t e;
                        for (int l = 0; l < 8; l++) begin
                            int v;
                            v = int'(lb[r][bb][l]) - 128;
                            e.d[l*8 +: 8] = 8'(v);
                        end
                        e.c = 3'(r);
                        e.l = (y == h - 1) && (bb == nb - 1) && (r == 7);
                        q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0 || out_valid) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue_left", 64'(q.size()), 64'd0);
    endtask

    // Monitor: owns out_hold, compares every transfer against the scoreboard
    initial begin
        out_hold = 1'b0;
        forever begin
            @(negedge clk);
            out_hold = hold_force || (int'($urandom_range(99)) < hold_pct);
            if (resetn) begin
                if (arm_first && out_valid) begin
                    t_first_out = cyc;
                    arm_first   = 0;
                end
                if (out_valid && !out_hold) begin
                    if (q.size() == 0) begin
                        check("spurious_out", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_cnt", 64'(out_cnt), 64'(e.c));
                        check("out_last", 64'(out_last), 64'(e.l));
                    end
                    if (out_last) n_last++;
                end
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        x_size_m1 = 11'd15;
        y_size_m1 = 10'd7;
        repeat (3) @(negedge clk);
        check("rst_in_hold", 64'(in_hold), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 16x8 ramp, no sink stall, latency to first output
        n_last    = 0;
        arm_first = 1;
        send_frame(16, 8, 0, 100, 999);
        drain();
        check("ramp_latency", 64'(t_first_out - t_last_in), 64'd2);
        check("ramp_last_cnt", 64'(n_last), 64'd1);

        // Extreme pixel values 0 / 128 / 255 in an 8x8 frame
        n_last = 0;
        send_frame(8, 8, 1, 100, 999);
        drain();
        check("vals_last_cnt", 64'(n_last), 64'd1);

        // Random 256x64 frame, random valid and sink stalls
        n_last   = 0;
        hold_pct = 50;
        send_frame(256, 64, 2, 50, 999);
        drain();
        check("rand_last_cnt", 64'(n_last), 64'd1);
        hold_pct = 0;

        // Sink held: in_hold must rise exactly after 16 lines
        n_last     = 0;
        n_acc      = 0;
        hold_force = 1;
        fork
            send_frame(16, 24, 0, 100, 999);
            begin
                int g;
                g = 0;
                while (!in_hold && g < 2000) begin
                    @(negedge clk);
                    g++;
                end
                check("hold_rise_beats", 64'(n_acc), 64'd32);
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_out_cnt", 64'(out_cnt), 64'd0);
                repeat (10) @(negedge clk);
                check("hold_stays", 64'(in_hold), 64'd1);
                check("hold_no_accept", 64'(n_acc), 64'd32);
                hold_force = 0;
            end
        join
        drain();
        check("hold_last_cnt", 64'(n_last), 64'd1);

        // Back-to-back frames with a stalling sink
        n_last   = 0;
        hold_pct = 60;
        send_frame(16, 16, 2, 100, 999);
        send_frame(16, 16, 2, 100, 999);
        drain();
        check("b2b_last_cnt", 64'(n_last), 64'd2);
        hold_pct = 0;

        // Reset mid-frame with output pending, then a fresh frame
        hold_force = 1;
        send_frame(16, 16, 0, 100, 13);
        repeat (3) @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", out_data, 64'd0);
        check("async_rst_in_hold", 64'(in_hold), 64'd0);
        check("async_rst_cnt", 64'(out_cnt), 64'd0);
        q.delete();
        @(negedge clk);
        resetn     = 1'b1;
        hold_force = 0;
        n_last     = 0;
        @(negedge clk);
        send_frame(16, 16, 2, 100, 999);
        drain();
        check("post_rst_last_cnt", 64'(n_last), 64'd1);

        finish_all();
    end

endmodule
`default_nettype wire
